oc8051_su_gate_ctrl: RTL

//  Sequences the supervisor privilege counter (oc8051_priv_lvl) from committed control-flow events.

---
 rtl/oc8051_su_gate_ctrl_pkg.sv | 45 ++++
 rtl/oc8051_su_gate_ctrl_shadow_stack.sv | 62 ++++++
 rtl/oc8051_su_gate_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/oc8051_su_gate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_su_gate_ctrl_pkg
// Brief   : Shared types and helpers for the supervisor gate controller.
// Revision: 1.0 - initial release
// ============================================================================
package oc8051_su_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_SETTLE = 2'd2
  } su_state_e;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_CALL  = 3'd1,
    EV_RET   = 3'd2,
    EV_IRQ   = 3'd3,
    EV_MULTI = 3'd4
  } su_event_e;

  localparam int         c_MIRROR_W   = 7;
  localparam logic [6:0] c_MIRROR_MAX = 7'h7F;

  function automatic su_event_e decode_event(input logic call, input logic ret, input logic irq);
    logic [1:0] cnt;
    cnt = {1'b0, call} + {1'b0, ret} + {1'b0, irq};
    if (cnt > 2'd1) return EV_MULTI;
    if (call)       return EV_CALL;
    if (ret)        return EV_RET;
    if (irq)        return EV_IRQ;
    return EV_NONE;
  endfunction

  function automatic logic in_region(input logic [15:0] addr, input logic [15:0] base, input int sz_lg2);
    return (addr >> sz_lg2) == (base >> sz_lg2);
  endfunction

  function automatic logic is_aligned(input logic [15:0] addr, input int al_lg2);
    return (addr & ((16'd1 << al_lg2) - 16'd1)) == 16'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oc8051_su_gate_ctrl_shadow_stack.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_su_shadow_stack
// Brief   : DEPTH x 1-bit LIFO; a push when full overwrites the top entry.
// Revision: 1.0 - initial release
// ============================================================================
module oc8051_su_shadow_stack #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_push_bit,
  input  logic i_pop,
  output logic o_top_bit,
  output logic o_empty,
  output logic o_ovf
);

  localparam int c_DW = $clog2(DEPTH + 1);
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [c_DW-1:0]  r_depth;
  logic [DEPTH-1:0] r_mem;
  logic             r_ovf;
  logic             w_full;
  logic [c_AW-1:0]  w_wr_idx;
  logic [c_AW-1:0]  w_top_idx;
  logic [DEPTH-1:0] w_wr_sel;

  assign w_full    = (r_depth == c_DW'(DEPTH));
  assign w_wr_idx  = w_full ? c_AW'(DEPTH - 1) : r_depth[c_AW-1:0];
  assign w_top_idx = c_AW'(r_depth - c_DW'(1));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign w_wr_sel[gi] = i_push && (w_wr_idx == c_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_mem <= (r_mem & ~w_wr_sel) | ({DEPTH{i_push_bit}} & w_wr_sel);
      if (i_push) begin
        if (w_full) r_ovf <= 1'b1;
        else        r_depth <= r_depth + c_DW'(1);
      end else if (i_pop && !o_empty) begin
        r_depth <= r_depth - c_DW'(1);
      end
    end
  end

  assign o_top_bit = r_mem[w_top_idx];
  assign o_empty   = (r_depth == '0);
  assign o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/oc8051_su_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_su_gate_ctrl
// Brief   : Turns committed call/ret/irq events into privilege counter pulses.
// Revision: 1.0 - initial release
// ============================================================================
module oc8051_su_gate_ctrl
  import oc8051_su_gate_ctrl_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] GATE_BASE   = 16'h0100,
  parameter int          GATE_SZ_LG2 = 8,
  parameter int          GATE_AL_LG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_su_en,
  input  logic        i_call_valid,
  input  logic [15:0] i_call_target,
  input  logic        i_ret_valid,
  input  logic        i_irq_ack,
  input  logic        i_priv_lvl,
  output logic        o_enter_su_mode,
  output logic        o_leave_su_mode,
  output logic        o_stall,
  output logic        o_su_fault,
  output logic        o_proto_err,
  output logic        o_ovf_sticky,
  output logic [15:0] o_fault_addr
);

  su_state_e              r_state, w_state_nxt;
  logic                   r_dir_enter;
  logic [c_MIRROR_W-1:0]  r_mirror;
  logic                   r_su_fault, r_proto_err;
  logic [15:0]            r_fault_addr;

  su_event_e w_event;
  logic w_in_region, w_hit;
  logic w_push, w_push_bit, w_pop, w_top_bit, w_empty;
  logic w_req_enter, w_req_leave, w_gate_viol, w_proto;
  logic w_sat_fault, w_underflow, w_start, w_settle_bad;

  assign w_event     = decode_event(i_call_valid, i_ret_valid, i_irq_ack);
  assign w_in_region = in_region(i_call_target, GATE_BASE, GATE_SZ_LG2);
  assign w_hit       = w_in_region && is_aligned(i_call_target, GATE_AL_LG2);

  oc8051_su_shadow_stack #(.DEPTH(DEPTH)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_bit (w_push_bit),
    .i_pop      (w_pop),
    .o_top_bit  (w_top_bit),
    .o_empty    (w_empty),
    .o_ovf      (o_ovf_sticky)
  );

  always_comb begin
    w_push      = 1'b0;
    w_push_bit  = 1'b0;
    w_pop       = 1'b0;
    w_req_enter = 1'b0;
    w_req_leave = 1'b0;
    w_gate_viol = 1'b0;
    w_proto     = 1'b0;
    case (w_event)
      EV_NONE:  ;
      EV_MULTI: w_proto = 1'b1;
      default: begin
        // Events arriving mid-transition are dropped, never queued.
        if (r_state != ST_IDLE) begin
          w_proto = 1'b1;
        end else begin
          case (w_event)
            EV_IRQ: begin
              w_push      = 1'b1;
              w_push_bit  = i_su_en;
              w_req_enter = i_su_en;
            end
            EV_CALL: begin
              w_push      = 1'b1;
              w_push_bit  = i_su_en && w_hit;
              w_req_enter = i_su_en && w_hit;
              w_gate_viol = i_su_en && !w_hit && !i_priv_lvl && w_in_region;
            end
            EV_RET: begin
              if (w_empty) begin
                w_proto = 1'b1;
              end else begin
                w_pop       = 1'b1;
                w_req_leave = i_su_en && w_top_bit;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    w_sat_fault  = w_req_enter && (r_mirror == c_MIRROR_MAX);
    w_underflow  = w_req_leave && (r_mirror == '0);
    w_start      = (w_req_enter && !w_sat_fault) || (w_req_leave && !w_underflow);
    w_settle_bad = (r_state == ST_SETTLE) && ((r_mirror != '0) != i_priv_lvl);

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_XFER;
      ST_XFER:   w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    o_enter_su_mode = (r_state == ST_XFER) && r_dir_enter;
    o_leave_su_mode = (r_state == ST_XFER) && !r_dir_enter;
    o_stall         = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir_enter  <= 1'b0;
      r_mirror     <= {{(c_MIRROR_W-1){1'b0}}, i_su_en};
      r_su_fault   <= 1'b0;
      r_proto_err  <= 1'b0;
      r_fault_addr <= 16'h0;
    end else begin
      if (r_state == ST_IDLE && w_start) r_dir_enter <= w_req_enter;
      // Mirror tracks the privilege counter, moving on the same edge the pulse lands.
      if (r_state == ST_XFER)
        r_mirror <= r_dir_enter ? r_mirror + 7'd1 : r_mirror - 7'd1;
      r_su_fault  <= w_gate_viol || w_sat_fault || w_settle_bad;
      r_proto_err <= w_proto || w_underflow;
      if (w_gate_viol) r_fault_addr <= i_call_target;
    end
  end

  assign o_su_fault   = r_su_fault;
  assign o_proto_err  = r_proto_err;
  assign o_fault_addr = r_fault_addr;

endmodule
`default_nettype wire
